// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared arbiter state encoding and width helper.
package axis_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first request above last_served (wrapping).
module rr_pick
    import axis_arb_pkg::*;
#(
    parameter int S_COUNT  = 4,
    parameter int ID_WIDTH = clog2_min1(S_COUNT)
) (
    input  logic [S_COUNT-1:0]  i_request,
    input  logic [ID_WIDTH-1:0] i_last_served,
    output logic                o_valid,
    output logic [ID_WIDTH-1:0] o_index
);

    always_comb begin
        int j;
        o_valid = |i_request;
        o_index = '0;
        j       = 0;
        // descending scan so the smallest offset from last_served wins
        for (int k = S_COUNT; k >= 1; k--) begin
            j = (int'(i_last_served) + k) % S_COUNT;
            if (i_request[j]) o_index = ID_WIDTH'(j);
        end
    end

endmodule

// File: rtl/axis_pkt_rr_arb.sv
// axis_pkt_rr_arb: packet-granular round-robin AXIS arbiter with a registered master
// port tagging each beat with its source index on tid.
module axis_pkt_rr_arb
    import axis_arb_pkg::*;
#(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
    parameter int ID_WIDTH   = clog2_min1(S_COUNT)
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [S_COUNT-1:0]           s_axis_tvalid,
    output logic [S_COUNT-1:0]           s_axis_tready,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [S_COUNT-1:0]           s_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]        m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic [ID_WIDTH-1:0]          m_axis_tid,
    output logic                         busy
);

    arb_state_t            r_state, w_state_nxt;
    logic [ID_WIDTH-1:0]   r_grant, r_last_served, w_pick_idx;
    logic                  w_pick_valid, w_busy, w_out_ready, w_accept, w_done;
    logic                  r_m_tvalid, r_m_tlast;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic [KEEP_WIDTH-1:0] r_m_tkeep;
    logic [ID_WIDTH-1:0]   r_m_tid;

    rr_pick #(.S_COUNT(S_COUNT), .ID_WIDTH(ID_WIDTH)) u_pick (
        .i_request     (s_axis_tvalid),
        .i_last_served (r_last_served),
        .o_valid       (w_pick_valid),
        .o_index       (w_pick_idx)
    );

    // the output slot is free when empty or draining this cycle
    assign w_out_ready   = m_axis_tready | ~r_m_tvalid;
    assign w_busy        = (r_state == ARB_BUSY);
    assign s_axis_tready = w_busy ? (S_COUNT'(w_out_ready) << r_grant) : '0;
    assign w_accept      = w_busy & s_axis_tvalid[r_grant] & w_out_ready;
    assign w_done        = w_accept & s_axis_tlast[r_grant];

    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = (r_state == ARB_IDLE) ? (w_pick_valid ? ARB_BUSY : ARB_IDLE)
                                            : (w_done ? ARB_IDLE : ARB_BUSY);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= ARB_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_grant       <= '0;
            r_last_served <= ID_WIDTH'(S_COUNT - 1);
        end else begin
            if (r_state == ARB_IDLE && w_pick_valid) r_grant <= w_pick_idx;
            if (w_done) r_last_served <= r_grant;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tid    <= '0;
        end else if (w_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= s_axis_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
            r_m_tkeep  <= s_axis_tkeep[r_grant*KEEP_WIDTH +: KEEP_WIDTH];
            r_m_tlast  <= s_axis_tlast[r_grant];
            r_m_tid    <= r_grant;
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tid    = r_m_tid;
    assign busy          = w_busy;

endmodule

// File: tb/tb_axis_pkt_rr_arb.sv
// tb_axis_pkt_rr_arb: randomized scoreboard bench; expected packet order comes from a
// queue-level round-robin model applied to whole packets.
module tb_axis_pkt_rr_arb;

    localparam int S = 4, DW = 8, KW = 1, IW = 2;

    logic              aclk = 1'b0, aresetn = 1'b0;
    logic [S-1:0]      s_tvalid, s_tready, s_tlast;
    logic [S*DW-1:0]   s_tdata;
    logic [S*KW-1:0]   s_tkeep;
    logic              m_tvalid, m_tready, m_tlast, busy;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [IW-1:0]     m_tid;

    always #5 aclk = ~aclk;

    axis_pkt_rr_arb #(.S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tid    (m_tid),
        .busy          (busy)
    );

    typedef struct packed {logic [DW-1:0] d; logic [KW-1:0] k; logic l;} beat_t;
    typedef struct packed {logic [DW-1:0] d; logic [KW-1:0] k; logic l; logic [IW-1:0] id;} exp_t;

    beat_t    stage[S][$];
    beat_t    sq[S][$];
    exp_t     eq[$];
    int       ptr = S - 1;
    logic [S-1:0] in_pkt = '0;
    int       drop_pct = 0, rdy_pct = 100;
    int       total = 0, bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic add_pkt(input int src, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = DW'($urandom);
            b.k = KW'($urandom);
            b.l = (i == len - 1);
            stage[src].push_back(b);
        end
    endtask

    function automatic bit stage_pending();
        for (int i = 0; i < S; i++) if (stage[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit src_pending();
        for (int i = 0; i < S; i++) if (sq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Whole-packet round robin: after serving p, the next packet comes from the first
    // source above p (wrapping) that still has a packet waiting.
    task automatic commit();
        int    src;
        beat_t b;
        while (stage_pending()) begin
            src = -1;
            for (int k = 1; k <= S; k++)
                if (src < 0 && stage[(ptr + k) % S].size() > 0) src = (ptr + k) % S;
            do begin
                b = stage[src].pop_front();
                sq[src].push_back(b);
                eq.push_back('{d: b.d, k: b.k, l: b.l, id: IW'(src)});
            end while (!b.l);
            ptr = src;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((eq.size() > 0 || src_pending() || busy) && n < 3000) begin
            @(posedge aclk);
            n++;
        end
        check("drain_timeout", 32'(n < 3000), 32'd1);
        repeat (2) @(posedge aclk);
        #3;
    endtask

    task automatic reset_pulse();
        @(posedge aclk);
        #3 aresetn = 1'b0;
        eq.delete();
        for (int i = 0; i < S; i++) begin
            sq[i].delete();
            stage[i].delete();
        end
        in_pkt = '0;
        ptr    = S - 1;
        #1;
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tready", 32'(s_tready), 32'd0);
        @(posedge aclk);
        #3 aresetn = 1'b1;
    endtask

    // source drivers: present head beat, optionally stall mid-packet, advance on handshake
    initial begin
        logic [S-1:0] acc;
        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; m_tready = 1'b1;
        forever begin
            @(negedge aclk);
            for (int i = 0; i < S; i++) begin
                if (sq[i].size() > 0 && !(in_pkt[i] && $urandom_range(99) < drop_pct)) begin
                    s_tvalid[i]         = 1'b1;
                    s_tdata[i*DW +: DW] = sq[i][0].d;
                    s_tkeep[i*KW +: KW] = sq[i][0].k;
                    s_tlast[i]          = sq[i][0].l;
                end else begin
                    s_tvalid[i]         = 1'b0;
                    s_tdata[i*DW +: DW] = DW'($urandom);
                    s_tlast[i]          = 1'($urandom);
                end
            end
            m_tready = ($urandom_range(99) < rdy_pct);
            #1 acc = s_tvalid & s_tready;
            @(posedge aclk);
            #1;
            if (aresetn)
                for (int i = 0; i < S; i++)
                    if (acc[i] && sq[i].size() > 0) begin
                        in_pkt[i] = !sq[i][0].l;
                        void'(sq[i].pop_front());
                    end
        end
    end

    // monitor: pops expected beats on every output handshake
    initial begin
        exp_t e;
        logic hold;
        logic [DW-1:0] pd;
        logic [IW-1:0] pid;
        hold = 1'b0; pd = '0; pid = '0;
        forever begin
            @(negedge aclk);
            #2;
            check("tready_onehot", 32'($countones(s_tready) <= 1), 32'd1);
            if (!aresetn) hold = 1'b0;
            else begin
                if (hold) check("hold_stable", {m_tvalid, m_tdata, m_tid}, {1'b1, pd, pid});
                if (m_tvalid && m_tready) begin
                    if (eq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat actual=%0h tid=%0d required=none", m_tdata, m_tid);
                    end else begin
                        e = eq.pop_front();
                        check("beat", {m_tdata, m_tkeep, m_tlast, m_tid}, {e.d, e.k, e.l, e.id});
                    end
                end
                hold = m_tvalid && !m_tready;
                pd   = m_tdata;
                pid  = m_tid;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        check("reset_out", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid}, '0);
        check("reset_tready", 32'(s_tready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge aclk);
        #3 aresetn = 1'b1;

        // single source latency and back-to-back beats
        @(posedge aclk);
        #3;
        stage[2].push_back('{d: 8'h11, k: 1'b1, l: 1'b0});
        stage[2].push_back('{d: 8'h22, k: 1'b1, l: 1'b0});
        stage[2].push_back('{d: 8'h33, k: 1'b1, l: 1'b1});
        commit();
        @(negedge aclk); #3 check("lat_n1", 32'(m_tvalid), 32'd0);
        @(negedge aclk); #3 check("lat_n2", {m_tvalid, busy}, {1'b0, 1'b1});
        @(negedge aclk); #3 check("lat_b0", {m_tvalid, m_tdata, m_tid, m_tlast}, {1'b1, 8'h11, 2'd2, 1'b0});
        @(negedge aclk); #3 check("lat_b1", {m_tvalid, m_tdata, m_tid, m_tlast}, {1'b1, 8'h22, 2'd2, 1'b0});
        @(negedge aclk); #3 check("lat_b2", {m_tvalid, m_tdata, m_tid, m_tlast}, {1'b1, 8'h33, 2'd2, 1'b1});
        drain();

        // all four sources, two rounds of 2-beat packets from reset
        reset_pulse();
        for (int r = 0; r < 2; r++) for (int i = 0; i < S; i++) add_pkt(i, 2);
        commit();
        drain();

        // backpressure on a 4-beat packet
        rdy_pct = 40;
        add_pkt(1, 4);
        commit();
        drain();

        // mid-packet stalls with a competing requester
        reset_pulse();
        rdy_pct = 100; drop_pct = 70;
        add_pkt(1, 4); add_pkt(3, 2);
        commit();
        drain();

        // fairness: continuous requester vs. a single packet
        drop_pct = 0;
        for (int i = 0; i < 3; i++) add_pkt(0, 3);
        add_pkt(1, 2);
        commit();
        drain();

        // randomized mixes
        for (int it = 0; it < 8; it++) begin
            drop_pct = $urandom_range(50);
            rdy_pct  = $urandom_range(100, 30);
            for (int i = 0; i < S; i++)
                for (int p = $urandom_range(3); p > 0; p--) add_pkt(i, $urandom_range(4, 1));
            commit();
            drain();
        end

        // reset in the middle of a packet, then lowest-index requester wins
        rdy_pct = 100; drop_pct = 0;
        add_pkt(1, 6);
        commit();
        repeat (3) @(posedge aclk);
        reset_pulse();
        add_pkt(3, 2); add_pkt(2, 2);
        commit();
        drain();

        check("queue_empty", 32'(eq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
